// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter; the head entry is always visible on o_data.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_l,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (!reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_flow.sv
// UART transmitter with byte FIFO and CTS flow control, 8N1/8N2 frames.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_flow
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_l,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    input  logic                          txen,
    input  logic [DIV_W-1:0]              div,
    input  logic                          nstop,
    input  logic                          cts_l,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_en,
    input  logic                          parity_odd,
`endif
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = $clog2(UART_DATA_BITS);

    uart_state_t      r_state, w_state_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic [DIV_W-1:0] r_baud, w_baud_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic             r_nstop, w_nstop_next;
    logic             r_stop2, w_stop2_next;
    logic             r_txd, w_txd_next;
    logic             r_busy, w_busy_next;
    logic [1:0]       r_cts_sync;
`ifdef UART_TX_PARITY_EN
    logic             r_par_en, w_par_en_next;
    logic             r_par_bit, w_par_bit_next;
`endif

    logic [7:0] w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_load;
    logic       w_start_ok;
    logic       w_baud_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset_l (reset_l),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Registered count only, so a same-cycle pop never frees the slot combinationally.
    assign in_ready    = !w_full;
    assign w_start_ok  = !w_empty && txen && !r_cts_sync[1];
    assign w_baud_done = (r_baud == '0);
    assign txd         = r_txd;
    assign busy        = r_busy;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_baud_next    = r_baud;
        w_div_next     = r_div;
        w_nstop_next   = r_nstop;
        w_stop2_next   = r_stop2;
        w_txd_next     = r_txd;
        w_busy_next    = r_busy;
`ifdef UART_TX_PARITY_EN
        w_par_en_next  = r_par_en;
        w_par_bit_next = r_par_bit;
`endif
        w_pop  = 1'b0;
        w_load = 1'b0;

        case (r_state)
            IDLE: begin
                w_txd_next  = UART_IDLE_LEVEL;
                w_busy_next = 1'b0;
                if (w_start_ok) w_load = 1'b1;
            end
            START: begin
                if (w_baud_done) begin
                    w_state_next   = DATA;
                    w_txd_next     = r_shift[0];
                    w_bit_cnt_next = '0;
                    w_baud_next    = r_div;
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next = r_div;
                    if (r_bit_cnt == BW'(UART_DATA_BITS - 1)) begin
                        w_state_next = STOP;
                        w_txd_next   = UART_IDLE_LEVEL;
                        w_stop2_next = 1'b0;
`ifdef UART_TX_PARITY_EN
                        if (r_par_en) begin
                            w_state_next = PARITY;
                            w_txd_next   = r_par_bit;
                        end
`endif
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_txd_next     = r_shift[1];
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_baud_done) begin
                    w_state_next = STOP;
                    w_txd_next   = UART_IDLE_LEVEL;
                    w_stop2_next = 1'b0;
                    w_baud_next  = r_div;
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_baud_done) begin
                    if (r_nstop && !r_stop2) begin
                        w_stop2_next = 1'b1;
                        w_baud_next  = r_div;
                    end else if (w_start_ok) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                        w_busy_next  = 1'b0;
                        w_txd_next   = UART_IDLE_LEVEL;
                    end
                end else begin
                    w_baud_next = r_baud - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_txd_next   = UART_IDLE_LEVEL;
                w_busy_next  = 1'b0;
            end
        endcase

        // Frame start: shared by the idle path and the back-to-back path from STOP.
        if (w_load) begin
            w_pop          = 1'b1;
            w_state_next   = START;
            w_shift_next   = w_head;
            w_div_next     = div;
            w_baud_next    = div;
            w_nstop_next   = nstop;
            w_stop2_next   = 1'b0;
            w_bit_cnt_next = '0;
            w_txd_next     = 1'b0;
            w_busy_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
            w_par_en_next  = parity_en;
            w_par_bit_next = (^w_head) ^ parity_odd;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud     <= '0;
            r_div      <= '0;
            r_nstop    <= 1'b0;
            r_stop2    <= 1'b0;
            r_txd      <= UART_IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_cts_sync <= 2'b11;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_baud     <= w_baud_next;
            r_div      <= w_div_next;
            r_nstop    <= w_nstop_next;
            r_stop2    <= w_stop2_next;
            r_txd      <= w_txd_next;
            r_busy     <= w_busy_next;
            r_cts_sync <= {r_cts_sync[0], cts_l};
`ifdef UART_TX_PARITY_EN
            r_par_en   <= w_par_en_next;
            r_par_bit  <= w_par_bit_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Directed bench for uart_tx_flow: frame shape, CTS gating, FIFO full, back-to-back, reset abort.
module tb_uart_tx_flow;

    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset_l;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             txen;
    logic [DIV_W-1:0] div;
    logic             nstop;
    logic             cts_l;
    logic             txd;
    logic             busy;
    logic [CW-1:0]    fifo_count;
`ifdef UART_TX_PARITY_EN
    logic             parity_en;
    logic             parity_odd;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    uart_tx_flow #(
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset_l    (reset_l),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .txen       (txen),
        .div        (div),
        .nstop      (nstop),
        .cts_l      (cts_l),
`ifdef UART_TX_PARITY_EN
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
`endif
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        check($sformatf("push %02h ready", b), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int maxc, input string tag);
        int n = 0;
        while (txd !== 1'b0 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        check({tag, " start seen"}, 32'(n < maxc), 32'd1);
    endtask

    // Called on the first cycle of the start bit; returns on the cycle after the last stop bit.
    task automatic check_frame(input logic [7:0] d, input int dv, input int ns,
                               input int par, input string tag);
        logic bits [12];
        int   nb;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (par >= 0) begin
            bits[nb] = par[0];
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (ns != 0) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k <= dv; k++) begin
                check($sformatf("%s bit%0d cyc%0d {busy,txd}", tag, b, k),
                      {30'd0, busy, txd}, {30'd0, 1'b1, bits[b]});
                @(negedge clock);
            end
        end
        $display("frame %s: byte %02h, %0d bits x %0d cycles checked", tag, d, nb, dv + 1);
    endtask

    logic [7:0] fbytes [5];
    logic       saw_low;
    int         n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        txen     = 1'b1;
        div      = 16'd3;
        nstop    = 1'b0;
        cts_l    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("reset txd", 32'(txd), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        reset_l = 1'b1;
        repeat (3) @(negedge clock);

        // Basic 8N1 frame, div=3: 10 bits x 4 cycles, busy drops after 40 cycles.
        push(8'hA5);
        wait_start(10, "basic");
        check_frame(8'hA5, 3, 0, -1, "basic");
        check("basic busy end", 32'(busy), 32'd0);

        // CTS held off: nothing leaves for 100 cycles, then start 3 cycles after release.
        cts_l = 1'b1;
        repeat (3) @(negedge clock);
        push(8'h55);
        saw_low = 1'b0;
        repeat (100) begin
            if (txd !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
            @(negedge clock);
        end
        check("cts hold idle", 32'(saw_low), 32'd0);
        check("cts hold count", 32'(fifo_count), 32'd1);
        cts_l = 1'b0;
        @(negedge clock);
        check("cts sync cyc1 txd", 32'(txd), 32'd1);
        @(negedge clock);
        check("cts sync cyc2 txd", 32'(txd), 32'd1);
        @(negedge clock);
        check("cts start cyc3 txd", 32'(txd), 32'd0);
        check_frame(8'h55, 3, 0, -1, "cts");
        check("cts busy end", 32'(busy), 32'd0);

        // FIFO full with CTS off, then drain back-to-back while the 5th byte waits for a slot.
        fbytes[0] = 8'h3C; fbytes[1] = 8'h81; fbytes[2] = 8'hE7;
        fbytes[3] = 8'h5A; fbytes[4] = 8'h96;
        div   = 16'd1;
        cts_l = 1'b1;
        repeat (3) @(negedge clock);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = fbytes[i];
            check($sformatf("fill %0d ready", i), 32'(in_ready), 32'd1);
            @(negedge clock);
        end
        in_data = fbytes[4];
        check("full in_ready", 32'(in_ready), 32'd0);
        check("full fifo_count", 32'(fifo_count), 32'd4);
        cts_l = 1'b0;
        fork
            begin
                wait_start(10, "full");
                for (int i = 0; i < 5; i++)
                    check_frame(fbytes[i], 1, 0, -1, $sformatf("full%0d", i));
            end
            begin
                n = 0;
                while (in_ready !== 1'b1 && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                check("full slot frees", 32'(n < 20), 32'd1);
                check("full slot latency", 32'(n), 32'd3);
                @(negedge clock);
                in_valid = 1'b0;
                check("full 5th accepted count", 32'(fifo_count), 32'd4);
            end
        join
        check("full busy end", 32'(busy), 32'd0);
        check("full fifo empty", 32'(fifo_count), 32'd0);

        // div=0, two stop bits: 11-cycle frames, back-to-back.
        div   = 16'd0;
        nstop = 1'b1;
        cts_l = 1'b1;
        repeat (3) @(negedge clock);
        push(8'h00);
        push(8'hFF);
        cts_l = 1'b0;
        wait_start(10, "div0");
        check_frame(8'h00, 0, 1, -1, "div0_a");
        check_frame(8'hFF, 0, 1, -1, "div0_b");
        check("div0 busy end", 32'(busy), 32'd0);

        // CTS dropped during DATA does not disturb the frame.
        div   = 16'd3;
        nstop = 1'b0;
        repeat (3) @(negedge clock);
        push(8'hC3);
        wait_start(10, "midcts");
        fork
            check_frame(8'hC3, 3, 0, -1, "midcts");
            begin
                repeat (10) @(negedge clock);
                cts_l = 1'b1;
            end
        join
        check("midcts busy end", 32'(busy), 32'd0);
        cts_l = 1'b0;
        repeat (3) @(negedge clock);

        // Reset during data bit 4 aborts the frame and discards the queued byte.
        push(8'h0F);
        push(8'h81);
        wait_start(10, "rst");
        repeat (20) @(negedge clock);
        check("rst pre bit4 txd", 32'(txd), 32'd0);
        check("rst pre count", 32'(fifo_count), 32'd1);
        reset_l = 1'b0;
        @(negedge clock);
        check("rst txd", 32'(txd), 32'd1);
        check("rst fifo_count", 32'(fifo_count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        reset_l = 1'b1;
        saw_low = 1'b0;
        repeat (30) begin
            if (txd !== 1'b1) saw_low = 1'b1;
            @(negedge clock);
        end
        check("rst stays idle", 32'(saw_low), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity of 8'h07 is 1; odd parity is 0.
        div        = 16'd1;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push(8'h07);
        wait_start(10, "par_even");
        check_frame(8'h07, 1, 0, 1, "par_even");
        parity_odd = 1'b1;
        push(8'h07);
        wait_start(10, "par_odd");
        check_frame(8'h07, 1, 0, 0, "par_odd");
        check("par busy end", 32'(busy), 32'd0);
        parity_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
